// File: rtl/div_pkg.sv
// Shared types and constants for the sequential RV32M divider.
package div_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DIV_ITER = 32;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_step
  import div_pkg::*;
(
  input  logic [XLEN-1:0] remainder,
  input  logic            dividend_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_remainder,
  output logic            quotient_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // The remainder is always below the divisor, so bit XLEN of diff is a clean borrow flag.
  assign shifted        = {remainder, dividend_bit};
  assign diff           = shifted - {1'b0, divisor};
  assign quotient_bit   = ~diff[XLEN];
  assign next_remainder = quotient_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/div_unit_seq.sv
// Sequential 32-bit RV32M divider (DIV/DIVU/REM/REMU), one restoring step per cycle.
// Define DIV_UNIT_EARLY_OUT_EN to skip the iteration loop for trivially resolved operands.
module div_unit_seq
  import div_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CntW = $clog2(DIV_ITER);
  localparam logic [CntW-1:0] CntLoad = CntW'(DIV_ITER - 1);

  div_state_e      state;
  logic [CntW-1:0] cnt;
  div_op_e         op_q;
  logic [XLEN-1:0] quo, rem, dvs, a_orig;
  logic            bzero, ovf, neg_q, neg_r;

  logic            in_signed, ovf_in, early;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] step_rem, fix_res;
  logic            step_q, quot_op;

  assign in_signed = ~op_i[0];
  assign a_mag     = (in_signed && a_i[XLEN-1]) ? -a_i : a_i;
  assign b_mag     = (in_signed && b_i[XLEN-1]) ? -b_i : b_i;
  assign ovf_in    = in_signed && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);

`ifdef DIV_UNIT_EARLY_OUT_EN
  assign early = (b_i == '0) || ovf_in || (a_mag < b_mag);
`else
  assign early = 1'b0;
`endif

  div_step u_step (
    .remainder     (rem),
    .dividend_bit  (quo[XLEN-1]),
    .divisor       (dvs),
    .next_remainder(step_rem),
    .quotient_bit  (step_q)
  );

  assign quot_op = (op_q == OpDiv) || (op_q == OpDivu);

  always_comb begin
    fix_res = '0;
    if (bzero) begin
      fix_res = quot_op ? '1 : a_orig;
    end else if (ovf) begin
      fix_res = quot_op ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end else if (quot_op) begin
      fix_res = neg_q ? -quo : quo;
    end else begin
      fix_res = neg_r ? -rem : rem;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= StIdle;
      cnt      <= '0;
      op_q     <= OpDiv;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      bzero    <= 1'b0;
      ovf      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        StIdle, StDone: begin
          if (start_i) begin
            op_q   <= div_op_e'(op_i);
            a_orig <= a_i;
            dvs    <= b_mag;
            bzero  <= (b_i == '0);
            ovf    <= ovf_in;
            neg_q  <= in_signed && (a_i[XLEN-1] ^ b_i[XLEN-1]);
            neg_r  <= in_signed && a_i[XLEN-1];
            busy_o <= 1'b1;
            if (early) begin
              // Quotient is zero and remainder is |a|; FIX resolves the special cases.
              quo   <= '0;
              rem   <= a_mag;
              state <= StFix;
            end else begin
              quo   <= a_mag;
              rem   <= '0;
              cnt   <= CntLoad;
              state <= StCalc;
            end
          end else begin
            state <= StIdle;
          end
        end
        StCalc: begin
          rem <= step_rem;
          quo <= {quo[XLEN-2:0], step_q};
          if (cnt == '0) begin
            state <= StFix;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StFix: begin
          result_o <= fix_res;
          busy_o   <= 1'b0;
          valid_o  <= 1'b1;
          state    <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_seq.sv
// Self-checking bench for div_unit_seq: directed corner cases plus random operations.
module tb_div_unit_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy_o, valid_o;
  logic [31:0] result_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  longint      last_valid_cyc = 0;
  longint      cyc_now = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_now <= cyc_now + 1;

  div_unit_seq dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .result_o(result_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int  sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      2'b01:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_UNIT_EARLY_OUT_EN
    logic [31:0] ma, mb;
    bit sgn;
    sgn = (op == 2'b00) || (op == 2'b10);
    ma  = (sgn && a[31]) ? -a : a;
    mb  = (sgn && b[31]) ? -b : b;
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || ma < mb) return 2;
`endif
    return 34;
  endfunction

  // Issue one operation (accepted at the next edge) and wait for its result.
  // Returns at #1 after the edge that raised valid_o, so a follow-up call issues from DONE.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    int cyc;
    bit side_ok;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    op_i    = 2'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
    cyc     = 1;
    side_ok = 1'b1;
    while (!valid_o && cyc < 60) begin
      if (!busy_o) side_ok = 1'b0;
      if (inject && cyc == 10) begin
        start_i = 1'b1;
        op_i    = ~op;
        a_i     = ~a;
        b_i     = b + 32'd3;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk_i);
      #1;
      cyc++;
    end
    start_i = 1'b0;
    check_eq({tag, " latency"}, 32'(cyc), 32'(exp_lat(op, a, b)));
    check_eq({tag, " result"}, result_o, ref_res(op, a, b));
    check_eq({tag, " busy held"}, 32'(side_ok), 32'd1);
    check_eq({tag, " busy low at valid"}, 32'(busy_o), 32'd0);
    last_valid_cyc = cyc_now;
  endtask

  initial begin
    longint first_pulse;
    bit     saw_valid;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    op_i    = 2'b00;
    a_i     = '0;
    b_i     = '0;
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_eq("reset busy", 32'(busy_o), 32'd0);
    check_eq("reset valid", 32'(valid_o), 32'd0);
    check_eq("reset result", result_o, 32'd0);
    @(posedge clk_i);
    #1;

    run_op("divu 100/7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 1'b0);
    check_eq("remu 100/7 value", result_o, 32'd2);
    run_op("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("div -7/2 value", result_o, 32'hFFFF_FFFD);
    run_op("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check_eq("rem -7/2 value", result_o, 32'hFFFF_FFFF);
    run_op("divu 5/0", 2'b01, 32'd5, 32'd0, 1'b0);
    run_op("rem 5/0", 2'b10, 32'd5, 32'd0, 1'b0);
    run_op("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("div 3/-9", 2'b00, 32'd3, 32'hFFFF_FFF7, 1'b0);

    // Start pulsed mid-operation must be ignored.
    run_op("ignored start", 2'b01, 32'd1_000_000, 32'd13, 1'b1);

    // Back-to-back issue from DONE.
    run_op("b2b divu 20/4", 2'b01, 32'd20, 32'd4, 1'b0);
    first_pulse = last_valid_cyc;
    run_op("b2b remu 20/6", 2'b11, 32'd20, 32'd6, 1'b0);
    check_eq("b2b spacing", 32'(last_valid_cyc - first_pulse), 32'd34);

    // Reset in the middle of CALC aborts the operation.
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    op_i    = 2'b01;
    a_i     = 32'hFFFF_FFF0;
    b_i     = 32'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_eq("abort result", result_o, 32'd0);
    check_eq("abort busy", 32'(busy_o), 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk_i);
      #1;
      if (valid_o) saw_valid = 1'b1;
    end
    check_eq("abort no valid", 32'(saw_valid), 32'd0);
    run_op("post-reset divu 9/3", 2'b01, 32'd9, 32'd3, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rop;
      rop = 2'($urandom);
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 100);
        2:       rb = -32'($urandom_range(1, 100));
        3: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b0);
    end

    @(posedge clk_i);
    #1;
    check_eq("valid single pulse", 32'(valid_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_unit_seq.md
DIV_UNIT_SEQ -- requirements
Module: div_unit_seq

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port start_i, input, 1 bit: request a new operation; sampled only in IDLE or DONE.
REQ-004 SHALL have port op_i, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-005 SHALL have port a_i, input, 32 bits: dividend, captured on the accepting edge.
REQ-006 SHALL have port b_i, input, 32 bits: divisor, captured on the accepting edge.
REQ-007 SHALL have port busy_o, output, 1 bit: high in CALC and FIX.
REQ-008 SHALL have port valid_o, output, 1 bit: one-cycle pulse marking result_o as new.
REQ-009 SHALL have port result_o, output, 32 bits: quotient or remainder, held until the next valid_o pulse.

Function
REQ-010 SHALL implement the FSM IDLE -> CALC -> FIX -> DONE -> IDLE.
REQ-011 IDLE or DONE with start_i=1: SHALL latch op_i, a_i and b_i, load the iteration counter with 31, and enter CALC.
REQ-012 Start conditioning: for DIV/REM, SHALL take the magnitudes of a and b and record the quotient sign (sa^sb) and the remainder sign (sa).
REQ-013 CALC: SHALL perform one restoring step per cycle (shift the remainder left, shift in the next dividend bit, trial-subtract the divisor, keep the result if non-negative, set the quotient bit), for exactly 32 cycles, then enter FIX.
REQ-014 FIX: SHALL apply sign correction and the special cases, then load result_o.
REQ-015 DONE: SHALL assert valid_o for exactly one cycle; start_i in DONE SHALL be accepted (back-to-back issue, no idle bubble).
REQ-016 Latency: valid_o SHALL be high in the 34th cycle after the accepting edge (32 CALC + 1 FIX + 1 DONE).
REQ-017 start_i while busy_o=1 SHALL be ignored; latched operands SHALL NOT change.
REQ-018 Divisor zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return the dividend unchanged.
REQ-019 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-020 All arithmetic SHALL be 32-bit modulo; the trial subtraction SHALL be 33-bit so its sign bit gives the borrow.

Reset
REQ-021 rst_ni=0 at a clock edge SHALL force IDLE, busy_o=0, valid_o=0, result_o=0, counter=0.
REQ-022 Reset during CALC or FIX SHALL abort the operation with no valid_o pulse; the first start_i after release SHALL behave as from power-up.

Configuration
REQ-023 Macro DIV_UNIT_EARLY_OUT_EN SHALL gate the fast path.
REQ-024 With the macro defined: divisor zero, signed overflow, and unsigned |a|<|b| SHALL bypass CALC (IDLE -> FIX -> DONE), with valid_o 2 cycles after the accepting edge.
REQ-025 Without the macro: every operation SHALL take 34 cycles.
REQ-026 Results SHALL be bit-identical with and without the macro.

Structure
REQ-027 Shared package div_pkg SHALL hold the op_i encoding enum, the FSM state enum, and the constants XLEN=32 and DIV_ITER=32.
REQ-028 One combinational sub-module, div_step, SHALL implement a single restoring iteration: inputs remainder, dividend bit and divisor; outputs next remainder and quotient bit.
REQ-029 The top level SHALL hold the FSM, counter, operand/sign registers and result register.
REQ-030 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-031 DIVU a=100, b=7 -> result_o=14, valid_o at cycle 34; REMU same operands -> 2.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
REQ-033 DIVU a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; with DIV_UNIT_EARLY_OUT_EN defined, valid_o at cycle 2.
REQ-034 start_i pulsed at cycle 10 of an operation with different operands -> ignored; first result correct; busy_o stays high throughout.
REQ-035 rst_ni low for 1 cycle at cycle 15 of CALC -> no valid_o pulse, result_o=0; a following DIVU 9/3 -> 3 at cycle 34.
REQ-036 start_i held high in DONE (back-to-back DIVU 20/4 then REMU 20/6) -> valid_o pulses 34 cycles apart with results 5 then 2.
